rs_corrector: RTL and testbench

Error-correction back end for the RS(255,239) decoder path. Buffers each received codeword symbol while the decoder is computing the error pattern. When the decoder presents its error stream (`valid`/`error`), the block XORs each error symbol onto the matching buffered symbol and emits the corrected codeword. It also tags parity positions, pulses end-of-frame and reports per-frame statistics.

---
 rtl/rs_pkg.sv | 18 +
 rtl/rs_sym_buffer.sv | 56 +++++
 rtl/rs_corrector.sv | 95 +++++++++
 tb/tb_rs_corrector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Constants and types shared across the RS(255,239) encoder, decoder and corrector.
package rs_pkg;
    localparam int SYM_W = 8;
    localparam int N_MAX = 255;
    localparam int NCHK  = 16;
    localparam int T     = 8;

    typedef logic [SYM_W-1:0] rs_sym_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } frame_state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v, input logic inc);
        return (inc && v != 5'd31) ? v + 5'd1 : v;
    endfunction
endpackage

// File: rtl/rs_sym_buffer.sv
// Circular symbol RAM holding received symbols until the decoder's error stream arrives.
module rs_sym_buffer
    import rs_pkg::*;
#(
    parameter int SYM_W = rs_pkg::SYM_W,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [SYM_W-1:0] wr_data,
    input  logic             rd_req,
    output logic [SYM_W-1:0] rd_data,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_OCC = {1'b1, {AW{1'b0}}};

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      occ;
    logic             full, rd, wr;

    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign rd      = rd_req && !empty;
    // A same-cycle read frees a slot, so a full buffer can still accept a write.
    assign wr      = wr_en && (!full || rd);
    assign rd_data = mem[rp];

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp        <= '0;
            rp        <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            case ({wr, rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (wr_en && full && !rd) overflow  <= 1'b1;
            if (rd_req && empty)      underflow <= 1'b1;
        end
    end
endmodule

// File: rtl/rs_corrector.sv
// RS error-correction back end: XORs the decoder error stream onto buffered symbols.
//   state     | meaning
//   ST_IDLE   | no frame in progress; next valid cycle starts a frame
//   ST_ACTIVE | frame in progress; error counter accumulating
module rs_corrector
    import rs_pkg::*;
#(
    parameter int SYM_W = rs_pkg::SYM_W,
    parameter int AW    = 9,
    parameter int NCHK  = rs_pkg::NCHK
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [SYM_W-1:0] received,
    input  logic             dec_ena,
    input  logic [SYM_W-1:0] error,
    input  logic             valid,
    input  logic [7:0]       k,
    output logic [SYM_W-1:0] corrected,
    output logic             out_valid,
    output logic             is_parity,
    output logic             frame_end,
    output logic [4:0]       err_count,
    output logic             overflow,
    output logic             underflow
);
    logic [SYM_W-1:0] rd_data;
    logic             empty;
    logic [7:0]       pos, last_pos, par_start;
    logic             is_last, first;
    logic [4:0]       err_run, err_next;
    frame_state_t     state, state_next;

    rs_sym_buffer #(.SYM_W(SYM_W), .AW(AW)) u_buf (
        .clk       (clk),
        .clrn      (clrn),
        .wr_en     (dec_ena),
        .wr_data   (received),
        .rd_req    (valid),
        .rd_data   (rd_data),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign last_pos  = k - 8'd1;
    assign par_start = k - 8'(NCHK);
    assign is_last   = (pos == last_pos);

    always_comb begin
        state_next = state;
        first      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_next = ST_ACTIVE;
                    first      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!valid || is_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The opening cycle of a frame discards the previous frame's running count.
    assign err_next = sat_inc5(first ? 5'd0 : err_run, error != '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            pos       <= '0;
            err_run   <= '0;
            corrected <= '0;
            out_valid <= 1'b0;
            is_parity <= 1'b0;
            frame_end <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            out_valid <= valid;
            is_parity <= valid && (pos >= par_start);
            frame_end <= valid && is_last;
            if (valid) begin
                corrected <= empty ? error : (rd_data ^ error);
                err_run   <= err_next;
                pos       <= is_last ? 8'd0 : pos + 8'd1;
                if (is_last) err_count <= err_next;
            end else begin
                pos <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rs_corrector.sv
// Directed bench for rs_corrector with hand-computed symbol streams.
module tb_rs_corrector;
    import rs_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  received = '0;
    logic        dec_ena = 1'b0;
    logic [7:0]  error = '0;
    logic        valid = 1'b0;
    logic [7:0]  k = 8'd255;
    logic [7:0]  corrected;
    logic        out_valid, is_parity, frame_end, overflow, underflow;
    logic [4:0]  err_count;

    int checks = 0;
    int failures = 0;

    rs_corrector dut (
        .clk(clk), .clrn(clrn), .received(received), .dec_ena(dec_ena),
        .error(error), .valid(valid), .k(k), .corrected(corrected),
        .out_valid(out_valid), .is_parity(is_parity), .frame_end(frame_end),
        .err_count(err_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sym(input int i, input int seed);
        return 8'((i * 7) + (seed * 13) + 3);
    endfunction

    function automatic logic [7:0] noise(input int i);
        case (i)
            0: return 8'd10;
            1: return 8'd20;
            2: return 8'd30;
            default: return 8'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int seed, input bit add_noise);
        for (int i = 0; i < 255; i++) begin
            dec_ena  = 1'b1;
            received = add_noise ? (sym(i, seed) ^ noise(i)) : sym(i, seed);
            tick();
        end
        dec_ena = 1'b0;
    endtask

    task automatic do_reset();
        valid = 1'b0; dec_ena = 1'b0; error = '0; received = '0;
        clrn = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({corrected, out_valid, is_parity, frame_end, err_count, overflow, underflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got c=%h ov=%b p=%b fe=%b ec=%0d of=%b uf=%b, want all 0",
                     corrected, out_valid, is_parity, frame_end, err_count, overflow, underflow);
        end
    endtask

    // Reads one 255-symbol frame and checks data, parity tags and frame_end placement.
    task automatic read_frame(input string name, input int seed, input bit with_error, input logic [4:0] exp_ec);
        for (int i = 0; i < 255; i++) begin
            valid = 1'b1;
            error = with_error ? noise(i) : 8'd0;
            tick();
            checks++;
            if (corrected !== sym(i, seed) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s_data[%0d]: got %h ov=%b, want %h ov=1", name, i, corrected, out_valid, sym(i, seed));
            end
            checks++;
            if (is_parity !== (i >= 239) || frame_end !== (i == 254)) begin
                failures++;
                $display("FAIL %s_tags[%0d]: got p=%b fe=%b, want p=%b fe=%b", name, i, is_parity, frame_end, i >= 239, i == 254);
            end
        end
        checks++;
        if (err_count !== exp_ec) begin
            failures++;
            $display("FAIL %s_err_count: got %0d, want %0d", name, err_count, exp_ec);
        end
        valid = 1'b0; error = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || frame_end !== 1'b0 || err_count !== exp_ec) begin
            failures++;
            $display("FAIL %s_after: got ov=%b fe=%b ec=%0d, want ov=0 fe=0 ec=%0d", name, out_valid, frame_end, err_count, exp_ec);
        end
    endtask

    task automatic test_clean_frame();
        write_frame(0, 1'b0);
        read_frame("clean", 0, 1'b0, 5'd0);
    endtask

    task automatic test_correctable();
        write_frame(1, 1'b1);
        read_frame("correct", 1, 1'b1, 5'd3);
    endtask

    task automatic test_back_to_back();
        int fe_cnt = 0;
        int fe_at[2] = '{-1, -1};
        logic [7:0] exp;
        write_frame(2, 1'b0);
        for (int i = 0; i < 510; i++) begin
            valid   = 1'b1;
            error   = '0;
            dec_ena = (i < 255);
            received = (i < 255) ? sym(i, 3) : 8'd0;
            tick();
            exp = (i < 255) ? sym(i, 2) : sym(i - 255, 3);
            checks++;
            if (corrected !== exp || frame_end !== (i == 254 || i == 509)) begin
                failures++;
                $display("FAIL b2b_stream[%0d]: got %h fe=%b, want %h fe=%b", i, corrected, frame_end, exp, i == 254 || i == 509);
            end
            if (frame_end) begin
                if (fe_cnt < 2) fe_at[fe_cnt] = i;
                fe_cnt++;
            end
        end
        valid = 1'b0; dec_ena = 1'b0;
        tick();
        checks++;
        if (fe_cnt !== 2 || (fe_at[1] - fe_at[0]) !== 255) begin
            failures++;
            $display("FAIL b2b_frame_end: got %0d pulses spacing %0d, want 2 spacing 255", fe_cnt, fe_at[1] - fe_at[0]);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_flags: got of=%b uf=%b, want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int j = 0; j < 513; j++) begin
            dec_ena  = 1'b1;
            received = 8'(j) ^ 8'hA5;
            tick();
            if (j == 511) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_early: got %b after 512 writes, want 0", overflow);
                end
            end
        end
        dec_ena = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b after 513 writes, want 1", overflow);
        end
        for (int j = 0; j < 512; j++) begin
            valid = 1'b1; error = '0;
            tick();
            checks++;
            if (corrected !== (8'(j) ^ 8'hA5)) begin
                failures++;
                $display("FAIL ovf_readback[%0d]: got %h, want %h", j, corrected, 8'(j) ^ 8'hA5);
            end
        end
        valid = 1'b0;
        tick();
        checks++;
        if (underflow !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got of=%b uf=%b, want 1 0", overflow, underflow);
        end
    endtask

    task automatic test_underflow();
        valid = 1'b1; error = 8'h5A;
        tick();
        valid = 1'b0; error = '0;
        checks++;
        if (corrected !== 8'h5A || out_valid !== 1'b1 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow: got c=%h ov=%b uf=%b, want 5a 1 1", corrected, out_valid, underflow);
        end
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky: got %b, want 1", underflow);
        end
    endtask

    task automatic test_abort_reset();
        int bad_fe = 0;
        do_reset();
        write_frame(4, 1'b0);
        for (int i = 0; i < 100; i++) begin
            valid = 1'b1; error = '0;
            tick();
            if (frame_end !== 1'b0) bad_fe++;
        end
        valid = 1'b0;
        tick();
        // Resumed stream restarts at pos 0, so no parity tags in the next 10 reads.
        for (int j = 0; j < 10; j++) begin
            valid = 1'b1;
            tick();
            checks++;
            if (corrected !== sym(100 + j, 4) || is_parity !== 1'b0) begin
                failures++;
                $display("FAIL abort_resume[%0d]: got %h p=%b, want %h p=0", j, corrected, is_parity, sym(100 + j, 4));
            end
            if (frame_end !== 1'b0) bad_fe++;
        end
        checks++;
        if (bad_fe !== 0) begin
            failures++;
            $display("FAIL abort_frame_end: got %0d pulses, want 0", bad_fe);
        end
        @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if ({corrected, out_valid, is_parity, frame_end, err_count, overflow, underflow} !== '0) begin
            failures++;
            $display("FAIL midframe_reset: got c=%h ov=%b p=%b fe=%b ec=%0d of=%b uf=%b, want all 0",
                     corrected, out_valid, is_parity, frame_end, err_count, overflow, underflow);
        end
        valid = 1'b0;
        tick();
        clrn = 1'b1;
        write_frame(5, 1'b0);
        read_frame("post_reset", 5, 1'b0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_correctable();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
